// File: rtl/coeff_pair_loader_if.sv
// Bus bundle for coeff_pair_loader: control, ROM read port and
// coefficient-store write port grouped behind master/slave modports.
interface coeff_pair_loader_if #(
  parameter int IW = 7,
  parameter int CW = 12
);

  logic          start;
  logic          busy;
  logic          done;
  logic [8:0]    rom_addr;
  logic [15:0]   rom_data;
  logic          wr_en;
  logic          wr_ready;
  logic [IW-1:0] wr_addr;
  logic [CW-1:0] wr_even;
  logic [CW-1:0] wr_odd;

  // Loader side: drives addresses and write data.
  modport master (
    input  start,
    output busy,
    output done,
    output rom_addr,
    input  rom_data,
    output wr_en,
    input  wr_ready,
    output wr_addr,
    output wr_even,
    output wr_odd
  );

  // Environment side: ROM, coefficient store and controller.
  modport slave (
    output start,
    input  busy,
    input  done,
    input  rom_addr,
    output rom_data,
    input  wr_en,
    output wr_ready,
    input  wr_addr,
    input  wr_even,
    input  wr_odd
  );

endinterface

// File: rtl/coeff_pair_loader.sv
// Walks the pair ROM, unpacks each word into two coefficients and writes
// them out through a 2-entry buffer. Option macro: COEFF_LOADER_BITREV_EN.
module coeff_pair_loader #(
  parameter int PAIRS = 128,
  parameter int IW    = 7,
  parameter int DW    = 8,
  parameter int CW    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  coeff_pair_loader_if.master  bus
);

  localparam int CNTW = IW + 1;
  localparam logic [CNTW-1:0] NPAIRS = CNTW'(PAIRS);
  localparam logic [CNTW-1:0] LASTWR = CNTW'(PAIRS - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   rd_idx_q, rd_idx_d;
  logic [CNTW-1:0]   wr_idx_q, wr_idx_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              done_q, done_d;
  logic [2*DW-1:0]   buf_q [2];
  logic [2*DW-1:0]   buf_d [2];

  logic              wr_en;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        used;
  logic [2:0]        room;
  logic [2*DW-1:0]   head;
  logic [IW-1:0]     idx_map;

  // Handshake terms: a read may be issued while buffer plus in-flight
  // slot, after this cycle's pop, still leaves a free entry.
  always_comb begin
    wr_en = (occ_q != 2'd0);
    pop   = wr_en & bus.wr_ready;
    push  = inflight_q;
    used  = {1'b0, occ_q} + {2'b00, inflight_q};
    room  = 3'd2 + {2'b00, pop};
    issue = (state_q == S_RUN)
          & (rd_idx_q < NPAIRS)
          & (used < room);
  end

  // Next-state logic for the sequencer, counters and buffer.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    inflight_d = issue;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    done_d     = 1'b0;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          rd_idx_d = '0;
          wr_idx_d = '0;
          occ_d    = 2'd0;
          rd_ptr_d = 1'b0;
          wr_ptr_d = 1'b0;
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
        if (push) begin
          buf_d[wr_ptr_q] = bus.rom_data;
          wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LASTWR) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      done_q     <= done_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

`ifdef COEFF_LOADER_BITREV_EN
  // Bit-reversed pair index for NTT input ordering.
  always_comb begin
    idx_map = '0;
    for (int i = 0; i < IW; i++) begin
      idx_map[i] = wr_idx_q[IW-1-i];
    end
  end
`else
  // Natural pair index.
  always_comb begin
    idx_map = wr_idx_q[IW-1:0];
  end
`endif

  // Output drive: everything comes straight from registers.
  always_comb begin
    head         = buf_q[rd_ptr_q];
    bus.busy     = (state_q == S_RUN);
    bus.done     = done_q;
    bus.rom_addr = {{(9-IW){1'b0}}, rd_idx_q[IW-1:0]};
    bus.wr_en    = wr_en;
    bus.wr_addr  = idx_map;
    bus.wr_even  = {{(CW-DW){1'b0}}, head[2*DW-1:DW]};
    bus.wr_odd   = {{(CW-DW){1'b0}}, head[DW-1:0]};
  end

endmodule

// File: tb/tb_coeff_pair_loader.sv
// Scoreboard bench for coeff_pair_loader: directed timing loads,
// stalls, random back-pressure, mid-load reset and start handling.
module tb_coeff_pair_loader;

  localparam int PAIRS = 128;
  localparam int IW    = 7;
  localparam int CW    = 12;

  typedef struct {
    int addr;
    int ev;
    int od;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  coeff_pair_loader_if #(.IW(IW), .CW(CW)) bus ();

  coeff_pair_loader #(
    .PAIRS(PAIRS),
    .IW(IW),
    .DW(8),
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  logic [15:0] rom [PAIRS];
  int cyc      = 0;
  int t0       = 0;
  int checks   = 0;
  int errors   = 0;
  int n_wr     = 0;
  int first_wr = -1;
  int n_done   = 0;
  int done_rel = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data valid the cycle after the address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[IW-1:0]];

  function automatic int map_addr(input int k);
    int r;
    r = k;
`ifdef COEFF_LOADER_BITREV_EN
    r = 0;
    for (int i = 0; i < IW; i++) begin
      if (((k >> i) & 1) != 0) r = r + (1 << (IW - 1 - i));
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({tag, "_wr_even"}, int'(bus.wr_even), 0);
    chk({tag, "_wr_odd"}, int'(bus.wr_odd), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted write.
  always @(negedge clk) begin : mon
    exp_t e;
    int   rel;
    rel = cyc - t0;
    checks++;
    if (int'(dut.occ_q) > 2) begin
      errors++;
      $display("FAIL occ got %0d expected <=2", dut.occ_q);
    end
    if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_write addr %0d at rel %0d", bus.wr_addr, rel);
      end else begin
        e = sb.pop_front();
        if (int'(bus.wr_addr) != e.addr || int'(bus.wr_even) != e.ev ||
            int'(bus.wr_odd) != e.od) begin
          errors++;
          $display("FAIL write got a=%0d e=%0d o=%0d expected a=%0d e=%0d o=%0d",
                   bus.wr_addr, bus.wr_even, bus.wr_odd, e.addr, e.ev, e.od);
        end
      end
      n_wr++;
      if (first_wr < 0) first_wr = rel;
    end
    if (bus.done === 1'b1) begin
      n_done++;
      done_rel = rel;
    end
  end

  // mode 0 ready high, 1 stall 10..19, 2 random ready,
  // 3 reset in cycle 40, 4 start pulse in RUN, 5 start held high
  task automatic run_load(input int mode);
    int   need;
    int   exp_done;
    int   rel;
    bit   fin;
    exp_t e;
    need = (mode == 5) ? 2 : 1;
    exp_done = (mode == 1) ? 141 : (mode == 5) ? 262 : 131;
    for (int r = 0; r < need; r++) begin
      for (int k = 0; k < PAIRS; k++) begin
        e.addr = map_addr(k);
        e.ev   = int'(rom[k][15:8]);
        e.od   = int'(rom[k][7:0]);
        sb.push_back(e);
      end
    end
    n_wr = 0;
    first_wr = -1;
    n_done = 0;
    done_rel = -1;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.start = 1'b1;
    bus.wr_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(posedge clk);
      #1;
      rel = cyc - t0;
      if (rel == 1) begin
        chk("busy_c1", int'(bus.busy), 1);
        chk("rom_addr_c1", int'(bus.rom_addr), 0);
      end
      if (mode == 1 && rel >= 10 && rel <= 19) begin
        chk("stall_wr_en", int'(bus.wr_en), 1);
        chk("stall_wr_addr", int'(bus.wr_addr), map_addr(7));
        chk("stall_wr_even", int'(bus.wr_even), 14);
        chk("stall_wr_odd", int'(bus.wr_odd), 15);
      end
      if (mode == 5 && rel == 131) chk("busy_gap", int'(bus.busy), 0);
      if (mode == 5 && rel == 132) chk("busy_reload", int'(bus.busy), 1);
      if (mode == 3 && rel == 41) begin
        chk_zero("midrst");
        sb.delete();
        fin = 1'b1;
      end
      bus.start = (mode == 5 && rel < 133) || (mode == 4 && rel == 50);
      rst = (mode == 3 && rel == 40);
      if (mode == 1) bus.wr_ready = !(rel >= 10 && rel <= 19);
      else if (mode == 2) bus.wr_ready = 1'($urandom_range(0, 1));
      else bus.wr_ready = 1'b1;
      if (n_done >= need) fin = 1'b1;
    end
    chk("timeout", int'(fin), 1);
    bus.start = 1'b0;
    bus.wr_ready = 1'b1;
    rst = 1'b0;
    if (mode != 3) begin
      repeat (4) @(posedge clk);
      #1;
      chk("writes", n_wr, need * PAIRS);
      chk("sb_left", sb.size(), 0);
      chk("done_pulses", n_done, need);
      chk("busy_after", int'(bus.busy), 0);
      if (mode != 2) begin
        chk("done_cycle", done_rel, exp_done);
        chk("first_wr", first_wr, 3);
      end
    end else begin
      repeat (2) @(posedge clk);
      #1;
      chk_zero("postrst");
    end
  endtask

  task automatic fill_rom(input bit rnd);
    for (int k = 0; k < PAIRS; k++) begin
      if (rnd) rom[k] = 16'($urandom);
      else rom[k] = 16'(((2 * k) << 8) | (2 * k + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.wr_ready = 1'b0;
    fill_rom(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    run_load(0);
    run_load(1);
    fill_rom(1'b1);
    run_load(2);
    fill_rom(1'b0);
    run_load(3);
    run_load(0);
    run_load(4);
    run_load(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
